// File: rtl/alu_cmd_driver.sv
// ALU command driver: buffers funct3/funct7 commands, drives a combinational ALU
// from registered operands and returns results on a valid/ready channel.
// Optional statistics counters: define ALU_CMD_DRIVER_STATS_EN.
module alu_cmd_driver #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_funct3,
   input  logic             cmd_funct7b5,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [2:0]       alu_operation,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_c,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_illegal
`ifdef ALU_CMD_DRIVER_STATS_EN
   ,
   output logic [15:0]      stat_issued,
   output logic [15:0]      stat_illegal
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [2:0]       funct3;
      logic             funct7b5;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   cmd_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             cmd_ready_q;
   logic             push, pop, empty;

   logic [2:0]       alu_op_q, alu_op_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_illegal_q, rsp_illegal_d;
   logic             rsp_valid_q;

   cmd_t             head;
   logic [2:0]       dec_op;
   logic [WIDTH-1:0] dec_b;
   logic             dec_illegal;
   logic             dec_shift;

   assign push  = cmd_valid && cmd_ready_q;
   assign empty = (count_q == CNT_W'(0));
   assign head  = mem_q[rd_ptr_q];

   // Command FIFO storage and pointers
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{cmd_funct3, cmd_funct7b5, cmd_a, cmd_b};
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Ready is registered from the next occupancy, so a pop frees space one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q     <= count_d;
         cmd_ready_q <= (count_d != CNT_W'(DEPTH));
      end
   end

   // Decode of the FIFO head into ALU opcode and (masked) operand B
   always_comb begin
      dec_op      = 3'b000;
      dec_illegal = 1'b0;
      dec_shift   = 1'b0;
      case (head.funct3)
         3'b000: dec_op = head.funct7b5 ? 3'b001 : 3'b000;
         3'b001: begin
            dec_op    = 3'b101;
            dec_shift = 1'b1;
         end
         3'b100: dec_op = 3'b100;
         3'b101: begin
            dec_op    = head.funct7b5 ? 3'b111 : 3'b110;
            dec_shift = 1'b1;
         end
         3'b110: dec_op = 3'b011;
         3'b111: dec_op = 3'b010;
         default: dec_illegal = 1'b1;
      endcase
      dec_b = dec_shift ? (head.b & WIDTH'(WIDTH - 1)) : head.b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pop           = 1'b0;
      alu_op_d      = alu_op_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      rsp_data_d    = rsp_data_q;
      rsp_illegal_d = rsp_illegal_q;
      case (state_q)
         S_IDLE:  pop = !empty;
         S_ISSUE: begin
            rsp_data_d    = alu_c;
            rsp_illegal_d = 1'b0;
            state_d       = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
               pop     = !empty;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Illegal commands skip ISSUE and leave the ALU inputs untouched
      if (pop) begin
         if (dec_illegal) begin
            state_d       = S_RESP;
            rsp_data_d    = '0;
            rsp_illegal_d = 1'b1;
         end else begin
            state_d  = S_ISSUE;
            alu_op_d = dec_op;
            alu_a_d  = head.a;
            alu_b_d  = dec_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op_q      <= 3'b000;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         rsp_data_q    <= '0;
         rsp_illegal_q <= 1'b0;
         rsp_valid_q   <= 1'b0;
      end else begin
         alu_op_q      <= alu_op_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         rsp_data_q    <= rsp_data_d;
         rsp_illegal_q <= rsp_illegal_d;
         rsp_valid_q   <= (state_d == S_RESP);
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign alu_operation = alu_op_q;
   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_illegal   = rsp_illegal_q;

`ifdef ALU_CMD_DRIVER_STATS_EN
   logic        rsp_hs;
   logic [15:0] stat_issued_q, stat_illegal_q;

   assign rsp_hs = (state_q == S_RESP) && rsp_ready;

   // Saturating completion counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued_q  <= '0;
         stat_illegal_q <= '0;
      end else if (rsp_hs) begin
         if (rsp_illegal_q) begin
            if (stat_illegal_q != 16'hFFFF) stat_illegal_q <= stat_illegal_q + 16'd1;
         end else begin
            if (stat_issued_q != 16'hFFFF) stat_issued_q <= stat_issued_q + 16'd1;
         end
      end
   end

   assign stat_issued  = stat_issued_q;
   assign stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed testbench for alu_cmd_driver (WIDTH=8, DEPTH=4) with a behavioural ALU.
module tb_alu_cmd_driver;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [2:0]   cmd_funct3;
   logic         cmd_funct7b5;
   logic [W-1:0] cmd_a, cmd_b;
   logic [2:0]   alu_operation;
   logic [W-1:0] alu_a, alu_b, alu_c;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_illegal;
`ifdef ALU_CMD_DRIVER_STATS_EN
   logic [15:0]  stat_issued, stat_illegal;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_cmd_driver #(.WIDTH(W), .DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_funct3   (cmd_funct3),
      .cmd_funct7b5 (cmd_funct7b5),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .alu_operation(alu_operation),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_c        (alu_c),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_illegal  (rsp_illegal)
`ifdef ALU_CMD_DRIVER_STATS_EN
      ,
      .stat_issued  (stat_issued),
      .stat_illegal (stat_illegal)
`endif
   );

   // Combinational ALU seen by the driver
   always_comb begin
      case (alu_operation)
         3'b000:  alu_c = alu_a + alu_b;
         3'b001:  alu_c = alu_a - alu_b;
         3'b010:  alu_c = alu_a & alu_b;
         3'b011:  alu_c = alu_a | alu_b;
         3'b100:  alu_c = alu_a ^ alu_b;
         3'b101:  alu_c = alu_a << alu_b;
         3'b110:  alu_c = alu_a >> alu_b;
         default: alu_c = W'($signed(alu_a) >>> alu_b);
      endcase
   end

   typedef struct {
      logic [2:0]   f3;
      logic         b5;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   op;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      logic [W-1:0] data;
      logic         ill;
   } vec_t;

   vec_t vec [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Push continuously with rsp_ready low; returns how many commands were accepted
   task automatic fill(input logic [2:0] f3, output int acc);
      logic rdy;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         cmd_valid    = 1'b1;
         cmd_funct3   = f3;
         cmd_funct7b5 = 1'b0;
         cmd_a        = W'(8'h10 + acc);
         cmd_b        = 8'h01;
         rdy          = cmd_ready;
         @(negedge clk);
         if (rdy) acc++;
      end
      cmd_valid = 1'b0;
   endtask

   initial begin
      int acc;
      int got;
      int last;

      rst_n        = 1'b0;
      cmd_valid    = 1'b0;
      cmd_funct3   = '0;
      cmd_funct7b5 = 1'b0;
      cmd_a        = '0;
      cmd_b        = '0;
      rsp_ready    = 1'b1;

      //          f3      b5    a      b      op      ea     eb     data   ill
      vec[0]  = '{3'b000, 1'b0, 8'h7F, 8'h01, 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0};
      vec[1]  = '{3'b000, 1'b1, 8'h05, 8'h07, 3'b001, 8'h05, 8'h07, 8'hFE, 1'b0};
      vec[2]  = '{3'b111, 1'b0, 8'hF0, 8'h3C, 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0};
      vec[3]  = '{3'b101, 1'b1, 8'h80, 8'h09, 3'b111, 8'h80, 8'h01, 8'hC0, 1'b0};
      vec[4]  = '{3'b101, 1'b0, 8'h80, 8'h09, 3'b110, 8'h80, 8'h01, 8'h40, 1'b0};
      vec[5]  = '{3'b010, 1'b0, 8'h12, 8'h34, 3'b110, 8'h80, 8'h01, 8'h00, 1'b1};
      vec[6]  = '{3'b001, 1'b1, 8'h03, 8'h0A, 3'b101, 8'h03, 8'h02, 8'h0C, 1'b0};
      vec[7]  = '{3'b110, 1'b1, 8'hA5, 8'h0F, 3'b011, 8'hA5, 8'h0F, 8'hAF, 1'b0};
      vec[8]  = '{3'b100, 1'b0, 8'hFF, 8'h0F, 3'b100, 8'hFF, 8'h0F, 8'hF0, 1'b0};
      vec[9]  = '{3'b011, 1'b1, 8'h55, 8'h66, 3'b100, 8'hFF, 8'h0F, 8'h00, 1'b1};
      vec[10] = '{3'b000, 1'b0, 8'hFF, 8'h02, 3'b000, 8'hFF, 8'h02, 8'h01, 1'b0};

      repeat (2) @(negedge clk);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_data", 32'(rsp_data), 32'd0);
      chk("reset rsp_illegal", 32'(rsp_illegal), 32'd0);
      chk("reset alu_operation", 32'(alu_operation), 32'd0);
      chk("reset alu_a", 32'(alu_a), 32'd0);
      chk("reset alu_b", 32'(alu_b), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("cmd_ready after reset", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 11; i++) begin
         cmd_valid    = 1'b1;
         cmd_funct3   = vec[i].f3;
         cmd_funct7b5 = vec[i].b5;
         cmd_a        = vec[i].a;
         cmd_b        = vec[i].b;
         chk($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'd1);
         @(negedge clk);
         cmd_valid = 1'b0;
         chk($sformatf("v%0d rsp_valid T+1", i), 32'(rsp_valid), 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d alu_operation", i), 32'(alu_operation), 32'(vec[i].op));
         chk($sformatf("v%0d alu_a", i), 32'(alu_a), 32'(vec[i].ea));
         chk($sformatf("v%0d alu_b", i), 32'(alu_b), 32'(vec[i].eb));
         if (vec[i].ill) begin
            chk($sformatf("v%0d rsp_valid T+2", i), 32'(rsp_valid), 32'd1);
         end else begin
            chk($sformatf("v%0d rsp_valid T+2", i), 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d rsp_valid T+3", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d alu_operation held", i), 32'(alu_operation), 32'(vec[i].op));
         end
         chk($sformatf("v%0d rsp_data", i), 32'(rsp_data), 32'(vec[i].data));
         chk($sformatf("v%0d rsp_illegal", i), 32'(rsp_illegal), 32'(vec[i].ill));
         @(negedge clk);
         chk($sformatf("v%0d rsp_valid after hs", i), 32'(rsp_valid), 32'd0);
      end
`ifdef ALU_CMD_DRIVER_STATS_EN
      chk("stat_issued table", 32'(stat_issued), 32'd9);
      chk("stat_illegal table", 32'(stat_illegal), 32'd2);
`endif

      // Capacity: DEPTH+1 accepted with the response stalled, then in-order drain
      rsp_ready = 1'b0;
      fill(3'b000, acc);
      chk("capacity accepted", 32'(acc), 32'd5);
      chk("capacity cmd_ready", 32'(cmd_ready), 32'd0);
      rsp_ready = 1'b1;
      got  = 0;
      last = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (cyc == 0) chk("drain cmd_ready before pop", 32'(cmd_ready), 32'd0);
         if (cyc == 1) chk("drain cmd_ready after pop", 32'(cmd_ready), 32'd1);
         if (rsp_valid) begin
            chk($sformatf("drain data %0d", got), 32'(rsp_data), 32'(8'h11 + got));
            if (got > 0) chk($sformatf("drain gap %0d", got), 32'(cyc - last), 32'd2);
            else chk("drain first response", 32'(cyc), 32'd0);
            last = cyc;
            got++;
         end
         @(negedge clk);
      end
      chk("drain count", 32'(got), 32'd5);
`ifdef ALU_CMD_DRIVER_STATS_EN
      chk("stat_issued drain", 32'(stat_issued), 32'd14);
`endif

      // Reset during ISSUE with three commands still queued
      rsp_ready = 1'b0;
      fill(3'b100, acc);
      chk("refill accepted", 32'(acc), 32'd5);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("in ISSUE rsp_valid", 32'(rsp_valid), 32'd0);
      chk("in ISSUE alu_operation", 32'(alu_operation), 32'd4);
      #1 rst_n = 1'b0;
      #1;
      chk("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid reset alu_operation", 32'(alu_operation), 32'd0);
      chk("mid reset alu_a", 32'(alu_a), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         chk($sformatf("post reset rsp_valid c%0d", cyc), 32'(rsp_valid), 32'd0);
      end
      chk("post reset cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef ALU_CMD_DRIVER_STATS_EN
      chk("post reset stat_issued", 32'(stat_issued), 32'd0);
      chk("post reset stat_illegal", 32'(stat_illegal), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
